mem_bus_responder: RTL

//  Memory-side end of the CPU external bus: decodes o_astb/o_rd/o_wr/o_atomic and o_ad/o_tag from cpu,

---
 rtl/membus_pkg.sv | 19 +
 rtl/mem_bus_responder_if.sv | 25 ++
 rtl/membus_ram.sv | 26 ++
 rtl/mem_bus_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/membus_pkg.sv
// Shared types for the CPU external-bus memory responder: FSM states and the
// 72-bit storage word layout.
package membus_pkg;

  localparam int BUS_AW_MAX = 20;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RDWAIT,
    LOCKED
  } bus_state_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic [63:0] data;
  } word72_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU external bus as seen between the cpu (master) and the memory responder
// (slave): strobes, address/data, and the read-return path.
interface mem_bus_responder_if;
  logic [63:0] ad;
  logic [7:0]  tag;
  logic        astb;
  logic        atomic;
  logic        rd;
  logic        wr;
  logic [63:0] rdata;
  logic [7:0]  rtag;
  logic        busy;
  logic        err_proto;
  logic        err_range;

  modport master (
    output ad, tag, astb, atomic, rd, wr,
    input  rdata, rtag, busy, err_proto, err_range
  );

  modport slave (
    input  ad, tag, astb, atomic, rd, wr,
    output rdata, rtag, busy, err_proto, err_range
  );
endinterface

// File: rtl/membus_ram.sv
// Single-port synchronous word store, write-first. Contents are deliberately
// not reset so a program preloaded through the backdoor survives a cpu reset.
module membus_ram
  import membus_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  word72_t       wdata_i,
  output word72_t       rdata_o
);

  word72_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
      rdata_o     <= wdata_i;
    end else begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side end of the cpu external bus: address/read/write/atomic decode,
// read latency counter, protocol and range error pulses, backdoor preload.
module mem_bus_responder
  import membus_pkg::*;
#(
  parameter int AW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_responder_if.slave bus,
  input  logic               ld_en,
  input  logic [AW-1:0]      ld_addr,
  input  logic [71:0]        ld_data
);

  bus_state_t            state_q;
  logic [BUS_AW_MAX-1:0] addr_q;
  logic                  lock_q;
  logic [2:0]            cnt_q;
  logic [63:0]           rdata_q;
  logic [7:0]            rtag_q;
  logic                  busy_q;
  logic                  errProto_q;
  logic                  errRange_q;

  logic                  bothReq;
  logic                  inRange;
  logic                  ldOk;
  logic                  wrOk;
  logic                  ramWe;
  logic [AW-1:0]         ramAddr;
  word72_t               ramWdata;
  word72_t               ramRdata;

  assign bothReq = bus.rd & bus.wr;
  assign inRange = (addr_q >> AW) == '0;
  assign ldOk    = ld_en && (state_q == IDLE);
  assign wrOk    = bus.wr && !bus.rd && inRange &&
                   ((state_q == ADDR) || (state_q == LOCKED));

  // The RAM port normally reads the latched address every cycle, so by the
  // time the latency counter expires its output already holds mem[addr].
  always_comb begin
    ramWe    = ldOk | wrOk;
    ramAddr  = addr_q[AW-1:0];
    ramWdata = {bus.tag, bus.ad};
    if (ldOk) begin
      ramAddr  = ld_addr;
      ramWdata = ld_data;
    end
  end

  membus_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ramWe),
    .addr_i  (ramAddr),
    .wdata_i (ramWdata),
    .rdata_o (ramRdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rtag_q     <= '0;
      busy_q     <= 1'b0;
      errProto_q <= 1'b0;
      errRange_q <= 1'b0;
    end else begin
      errProto_q <= 1'b0;
      errRange_q <= 1'b0;
      if (ld_en && (state_q != IDLE)) errProto_q <= 1'b1;
      if (bothReq) errProto_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (!bothReq) begin
            if (bus.astb) begin
              addr_q  <= bus.ad[BUS_AW_MAX-1:0];
              lock_q  <= bus.atomic;
              state_q <= ADDR;
            end else if (bus.rd || bus.wr) begin
              errProto_q <= 1'b1;
            end
          end
        end

        ADDR: begin
          if (!bothReq) begin
            if (bus.rd) begin
              cnt_q      <= 3'(RD_LAT - 1);
              busy_q     <= 1'b1;
              errRange_q <= !inRange;
              state_q    <= RDWAIT;
            end else if (bus.wr) begin
              errProto_q <= lock_q;
              errRange_q <= !inRange;
              lock_q     <= 1'b0;
              state_q    <= IDLE;
            end else if (bus.astb) begin
              addr_q <= bus.ad[BUS_AW_MAX-1:0];
              lock_q <= bus.atomic;
            end
          end
        end

        // Bus requests are refused while the read drains; the countdown
        // itself is never disturbed.
        RDWAIT: begin
          if (bus.rd || bus.wr || bus.astb) errProto_q <= 1'b1;
          if (cnt_q == '0) begin
            rdata_q <= inRange ? ramRdata.data : '0;
            rtag_q  <= inRange ? ramRdata.tag : '0;
            busy_q  <= 1'b0;
            state_q <= lock_q ? LOCKED : IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end

        LOCKED: begin
          if (!bothReq) begin
            if (bus.wr) begin
              errRange_q <= !inRange;
              lock_q     <= 1'b0;
              state_q    <= IDLE;
            end else if (bus.astb) begin
              errProto_q <= 1'b1;
              addr_q     <= bus.ad[BUS_AW_MAX-1:0];
              lock_q     <= 1'b0;
              state_q    <= ADDR;
            end else if (bus.rd) begin
              errProto_q <= 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.rtag      = rtag_q;
  assign bus.busy      = busy_q;
  assign bus.err_proto = errProto_q;
  assign bus.err_range = errRange_q;

endmodule
